cpu_control_unit: RTL
=====================

# cpu_control_unit

Hardwired multi-cycle control FSM for the 8-bit accumulator CPU. It replaces the free-running sequence counter, 3-to-8 opcode decoder and hand-written control equations. It drives the bus-source select, register strobes, ALU opcode and a request/acknowledge handshake to the shared 32x8 data RAM, so the RAM can insert wait states. It sits between IR/carry flag and the datapath (bus_manager, DR/AC/IR/PC/AR registers, ALU, RAM).

## Interface
Parameters:
- ACK_TIMEOUT, 15: maximum cycles in a RAM state without mem_ack before the bus-error halt; 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- R  in  1  reset, asynchronous, active-low.
- ir  in  8  IR contents; ir[7:5] is the opcode, ir[4:0] the address.
- carry  in  1  ALU carry flag.
- mem_ack  in  1  RAM transfer done this cycle.
- bus_sel  out  3  bus source: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 RAM, 6 ROM, 7 TR.
- ld_ar, ld_pc, inc_pc, ld_dr, ld_ac, ld_ir  out  1 each  register strobes, taken on the next rising edge.
- alu_op  out  3  ALU function; equals ir[7:5] in EX, else 0.
- mem_req  out  1  RAM access request.
- mem_we  out  1  write qualifier; valid only while mem_req=1.
- halted  out  1  FSM is in HALT.
- bus_err  out  1  sticky; set on ACK_TIMEOUT expiry.
- state  out  3  current state code, for debug.

## Operation
- State codes: F0=0, F1=1, DEC=2, RD=3, EX=4, WR=5, JC=6, HALT=7.
- F0: bus_sel=1, ld_ar. Next state F1.
- F1: bus_sel=6, ld_ir, inc_pc. Next state DEC.
- DEC: bus_sel=4, ld_ar (AR<=ir[4:0]). Next state by opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 LDA, 6 ADDM go to RD.
  - 5 STA goes to WR.
  - 7 goes to HALT if ir[4:0]=31, else JC.
- RD: mem_req=1, mem_we=0, bus_sel=5. ld_dr=mem_ack (Mealy). Stay in RD while mem_ack=0; go to EX on mem_ack=1.
- EX: ld_ac=1, alu_op=ir[7:5]. Next state WR for opcode 6, else F0.
- WR: mem_req=1, mem_we=1, bus_sel=3. Stay in WR while mem_ack=0; go to F0 on mem_ack=1.
- JC: bus_sel=0, ld_pc=carry. Next state F0.
- HALT: all strobes and mem_req are 0 and halted=1. Only reset leaves HALT.
- Wait counter (8 bits):
  - Clears on entry to RD or WR and counts each cycle mem_ack=0 there.
  - When it reaches ACK_TIMEOUT with mem_ack still 0, set bus_err and go to HALT. The strobe for the failed transfer is not issued.
- Any output not listed for a state is 0; bus_sel is 0 in HALT.
- ir is sampled only in DEC, EX and JC. The block never writes IR outside F1.

## Timing
- Reset (R=0): state=F0 and bus_err=0 immediately. All outputs are forced to 0 combinationally while R=0, including mem_req mid-transfer. The first F0 cycle starts at the first rising edge after R rises.
- Cycles per instruction with zero wait states: ADD/SUB/AND/XOR/LDA 5, STA 4, ADDM 6, JC 4, HALT 4 to reach the state. Each cycle mem_ack=0 adds 1 cycle.
- mem_ack is sampled on the rising edge; an ack arriving while mem_req=0 is ignored.
- mem_req rises in the cycle the FSM enters RD/WR. It drops in the cycle after the ack edge, because the state has changed.
- mem_ack on the cycle the count reaches ACK_TIMEOUT counts as success; ack wins over timeout.
- JC with carry=0 behaves as a 4-cycle no-op.
- PC wrap (31+1=0) is owned by the PC register and is not the FSM's concern.

## Test plan
- Reset: hold R=0 across several edges, then pulse R low mid-RD. Required: all outputs 0 and state=0 while low; F0 on the first edge after release.
- ADD with zero wait: ir=8'h15, mem_ack=1 constantly. Required: state sequence 0,1,2,3,4,0; ld_dr in cycle 4, ld_ac with alu_op=0 in cycle 5.
- ADDM with 3 wait states on both accesses: ir=8'hD5. Required: RD holds for 4 cycles, then EX, then WR holds for 4 cycles with mem_we=1 and bus_sel=3; 12 cycles total.
- JC: ir=8'hEA with carry=1, then carry=0. Required: ld_pc=1 and bus_sel=0 in JC when carry=1; ld_pc=0 when carry=0; 4 cycles each.
- HALT: ir=8'hFF. Required: halted=1 from cycle 4 and stays 1 for 100 cycles with no strobes; reset clears it.
- Timeout: ACK_TIMEOUT=15, STA, mem_ack=0 forever. Required: bus_err=1 and state=7 after 15 WR cycles; ack on cycle 15 of a second run completes normally.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Hardwired multi-cycle control FSM for the 8-bit accumulator CPU.
// Sequences fetch/decode/execute, drives datapath strobes and a
// req/ack handshake to the shared RAM with a wait-state timeout.
module cpu_control_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       R,
  input  logic [7:0] ir,
  input  logic       carry,
  input  logic       mem_ack,
  output logic [2:0] bus_sel,
  output logic       ld_ar,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       ld_dr,
  output logic       ld_ac,
  output logic       ld_ir,
  output logic [2:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_F0 = 3'd0, S_F1 = 3'd1, S_DEC = 3'd2, S_RD = 3'd3,
    S_EX = 3'd4, S_WR = 3'd5, S_JC = 3'd6, S_HALT = 3'd7
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_bus_err;
  // Low for the cycle after reset release so the first F0 cycle begins
  // on the first rising edge after R rises.
  logic       r_run;

  logic [2:0] w_op;
  logic       w_in_mem;
  logic       w_timeout;
  logic       w_en;
  logic [2:0] w_bus_sel, w_alu_op;
  logic       w_ld_ar, w_ld_pc, w_inc_pc, w_ld_dr, w_ld_ac, w_ld_ir;
  logic       w_mem_req, w_mem_we, w_halted;

  assign w_op      = ir[7:5];
  assign w_in_mem  = (r_state == S_RD) || (r_state == S_WR);
  // Ack on the final allowed cycle still counts as success.
  assign w_timeout = w_in_mem && !mem_ack && (r_cnt == TO_LAST);
  assign w_en      = R && r_run;

  // State sequencing, wait counter and sticky bus error.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state   <= S_F0;
      r_cnt     <= 8'd0;
      r_bus_err <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        case (r_state)
          S_F0: r_state <= S_F1;
          S_F1: r_state <= S_DEC;
          S_DEC: begin
            r_cnt <= 8'd0;
            case (w_op)
              3'd5:    r_state <= S_WR;
              3'd7:    r_state <= (ir[4:0] == 5'd31) ? S_HALT : S_JC;
              default: r_state <= S_RD;
            endcase
          end
          S_RD: begin
            if (mem_ack) r_state <= S_EX;
            else if (w_timeout) begin
              r_state   <= S_HALT;
              r_bus_err <= 1'b1;
            end else r_cnt <= r_cnt + 8'd1;
          end
          S_EX: begin
            r_cnt   <= 8'd0;
            r_state <= (w_op == 3'd6) ? S_WR : S_F0;
          end
          S_WR: begin
            if (mem_ack) r_state <= S_F0;
            else if (w_timeout) begin
              r_state   <= S_HALT;
              r_bus_err <= 1'b1;
            end else r_cnt <= r_cnt + 8'd1;
          end
          S_JC:    r_state <= S_F0;
          default: r_state <= S_HALT;
        endcase
      end
    end
  end

  // Per-state control decode; ld_dr follows mem_ack in RD.
  always_comb begin
    w_bus_sel = 3'd0;
    w_alu_op  = 3'd0;
    w_ld_ar   = 1'b0;
    w_ld_pc   = 1'b0;
    w_inc_pc  = 1'b0;
    w_ld_dr   = 1'b0;
    w_ld_ac   = 1'b0;
    w_ld_ir   = 1'b0;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_halted  = 1'b0;
    case (r_state)
      S_F0:  begin w_bus_sel = 3'd1; w_ld_ar = 1'b1; end
      S_F1:  begin w_bus_sel = 3'd6; w_ld_ir = 1'b1; w_inc_pc = 1'b1; end
      S_DEC: begin w_bus_sel = 3'd4; w_ld_ar = 1'b1; end
      S_RD:  begin w_bus_sel = 3'd5; w_mem_req = 1'b1; w_ld_dr = mem_ack; end
      S_EX:  begin w_ld_ac = 1'b1; w_alu_op = w_op; end
      S_WR:  begin w_bus_sel = 3'd3; w_mem_req = 1'b1; w_mem_we = 1'b1; end
      S_JC:  begin w_bus_sel = 3'd0; w_ld_pc = carry; end
      default: w_halted = 1'b1;
    endcase
  end

  // Everything is forced low while in reset or before the first run edge.
  assign bus_sel = w_bus_sel & {3{w_en}};
  assign alu_op  = w_alu_op & {3{w_en}};
  assign ld_ar   = w_ld_ar & w_en;
  assign ld_pc   = w_ld_pc & w_en;
  assign inc_pc  = w_inc_pc & w_en;
  assign ld_dr   = w_ld_dr & w_en;
  assign ld_ac   = w_ld_ac & w_en;
  assign ld_ir   = w_ld_ir & w_en;
  assign mem_req = w_mem_req & w_en;
  assign mem_we  = w_mem_we & w_en;
  assign halted  = w_halted & w_en;
  assign bus_err = r_bus_err & R;
  assign state   = r_state & {3{R}};

endmodule
